// File: rtl/jtoutrun_adc.sv
// Out Run cabinet ADC: a CPU write latches one analogue/digital control channel and
// publishes it on dout after CONV_CYCLES cen ticks. Optional filter: JTOUTRUN_ADC_FILTER_EN.
module jtoutrun_adc #(
    parameter int CONV_CYCLES = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr,
    input  logic [2:0]  ch,
    input  logic [7:0]  joystick1,
    input  logic [15:0] joyana1,
    input  logic [15:0] joyana1b,
    input  logic [7:0]  motor_pos,
    output logic [7:0]  dout,
    output logic        busy,
    output logic        intn
);

    typedef enum logic {IDLE, CONV} state_t;

    localparam logic [7:0] LAST_TICK = 8'(CONV_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [2:0]  ch_reg, ch_next;
    logic [7:0]  sample_reg, sample_next;
    logic [7:0]  dout_reg, dout_next;
    logic        busy_reg, busy_next;
    logic        intn_reg, intn_next;
    logic [7:0]  sample_now;
    logic [7:0]  pedal_mag;
    logic [7:0]  result;
    logic        done;

    assign pedal_mag = {joyana1b[14:8], joyana1b[14]};

    // Input sample for the channel being requested by the current write
    always_comb begin
        sample_now = 8'hFF;
        case (ch)
            3'd0: begin
                if (!joystick1[0])      sample_now = 8'hD0;
                else if (!joystick1[1]) sample_now = 8'h20;
                else                    sample_now = joyana1[7:0] ^ 8'h80;
            end
            3'd1: begin
                if (!joystick1[3])      sample_now = 8'hF0;
                else if (joyana1b[15])  sample_now = ~pedal_mag;
                else                    sample_now = 8'h00;
            end
            3'd2: begin
                if (!joystick1[2])      sample_now = 8'hF0;
                else if (joyana1b[15])  sample_now = 8'h00;
                else                    sample_now = pedal_mag;
            end
            3'd3:    sample_now = motor_pos;
            default: sample_now = 8'hFF;
        endcase
    end

`ifdef JTOUTRUN_ADC_FILTER_EN
    logic [7:0] hist_reg  [4];
    logic [7:0] hist_next [4];
    logic [9:0] filt_sum;
    logic       hist_shift;

    assign hist_shift = done && (ch_reg == 3'd0);

    // Newest channel-0 sample enters at entry 0, oldest drops off entry 3
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_next[gi] = hist_shift ? sample_reg : hist_reg[gi];
            end else begin : g_tail
                assign hist_next[gi] = hist_shift ? hist_reg[gi-1] : hist_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) hist_reg[i] <= 8'h80;
            else     hist_reg[i] <= hist_next[i];
        end
    end

    assign filt_sum = 10'(sample_reg) + 10'(hist_reg[0]) + 10'(hist_reg[1]) + 10'(hist_reg[2]);
    assign result   = (ch_reg == 3'd0) ? filt_sum[9:2] : sample_reg;

    logic unused_bits;
    assign unused_bits = &{1'b0, joystick1[7:4], joyana1[15:8], joyana1b[7:0],
                           hist_reg[3], filt_sum[1:0]};
`else
    assign result = sample_reg;

    logic unused_bits;
    assign unused_bits = &{1'b0, joystick1[7:4], joyana1[15:8], joyana1b[7:0], ch_reg};
`endif

    // A write always restarts, even on the clk of the final tick
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        ch_next     = ch_reg;
        sample_next = sample_reg;
        dout_next   = dout_reg;
        busy_next   = busy_reg;
        intn_next   = intn_reg;
        done        = 1'b0;
        if (wr) begin
            state_next  = CONV;
            cnt_next    = 8'd0;
            ch_next     = ch;
            sample_next = sample_now;
            busy_next   = 1'b1;
            intn_next   = 1'b1;
        end else if (state_reg == CONV && cen) begin
            if (cnt_reg == LAST_TICK) begin
                done       = 1'b1;
                state_next = IDLE;
                dout_next  = result;
                busy_next  = 1'b0;
                intn_next  = 1'b0;
            end else begin
                cnt_next = cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 8'd0;
            ch_reg     <= 3'd0;
            sample_reg <= 8'h00;
            dout_reg   <= 8'h80;
            busy_reg   <= 1'b0;
            intn_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ch_reg     <= ch_next;
            sample_reg <= sample_next;
            dout_reg   <= dout_next;
            busy_reg   <= busy_next;
            intn_reg   <= intn_next;
        end
    end

    assign dout = dout_reg;
    assign busy = busy_reg;
    assign intn = intn_reg;

endmodule
